// File: rtl/tsc_multicycle_control_pkg.sv
// Opcode/funct constants and FSM state encoding shared by the TSC control unit and ALU.
package tsc_opcodes;

    localparam logic [3:0] OPCODE_BNE   = 4'd0;
    localparam logic [3:0] OPCODE_BEQ   = 4'd1;
    localparam logic [3:0] OPCODE_BGZ   = 4'd2;
    localparam logic [3:0] OPCODE_BLZ   = 4'd3;
    localparam logic [3:0] OPCODE_ADI   = 4'd4;
    localparam logic [3:0] OPCODE_ORI   = 4'd5;
    localparam logic [3:0] OPCODE_LHI   = 4'd6;
    localparam logic [3:0] OPCODE_LWD   = 4'd7;
    localparam logic [3:0] OPCODE_SWD   = 4'd8;
    localparam logic [3:0] OPCODE_JMP   = 4'd9;
    localparam logic [3:0] OPCODE_JAL   = 4'd10;
    localparam logic [3:0] OPCODE_RTYPE = 4'd15;

    localparam logic [5:0] FUNC_ADD = 6'd0;
    localparam logic [5:0] FUNC_SUB = 6'd1;
    localparam logic [5:0] FUNC_AND = 6'd2;
    localparam logic [5:0] FUNC_ORR = 6'd3;
    localparam logic [5:0] FUNC_WWD = 6'd28;
    localparam logic [5:0] FUNC_HLT = 6'd29;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    function automatic logic is_rtype_func(input logic [3:0] opcode, input logic [5:0] funct,
                                           input logic [5:0] which);
        return (opcode == OPCODE_RTYPE) && (funct == which);
    endfunction

endpackage

// File: rtl/tsc_inst_counter.sv
// Retired-instruction counter; wraps modulo 2^WORD_W.
module tsc_inst_counter #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [WORD_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WORD_W'(1);
        end
    end

endmodule

// File: rtl/tsc_multicycle_control.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM for the 16-bit TSC datapath.
module tsc_multicycle_control
    import tsc_opcodes::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              input_ready,
    output logic              read_m,
    output logic              write_m,
    output logic              i_or_d,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_src,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              alu_src_b,
    output logic [3:0]        aluop,
    output logic [5:0]        alu_funct,
    output logic              output_port_we,
    output logic              is_halted,
    output logic [WORD_W-1:0] num_inst
);

    state_t state;

    wire is_add = is_rtype_func(opcode, funct, FUNC_ADD);
    wire is_wwd = is_rtype_func(opcode, funct, FUNC_WWD);
    wire is_hlt = is_rtype_func(opcode, funct, FUNC_HLT);

    // NOTE: every sequential register here uses <= so all of them see the pre-edge state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IF;
            is_halted <= 1'b0;
        end else begin
            unique case (state)
                S_IF: if (input_ready) state <= S_ID;
                S_ID: begin
                    if (is_hlt) begin
                        state     <= S_HALT;
                        is_halted <= 1'b1;
                    end else begin
                        state <= S_EX;
                    end
                end
                S_EX: begin
                    if (is_add || opcode == OPCODE_ADI || opcode == OPCODE_LHI)
                        state <= S_WB;
                    else if (opcode == OPCODE_LWD || opcode == OPCODE_SWD)
                        state <= S_MEM;
                    else
                        state <= S_IF;
                end
                S_MEM: if (input_ready) state <= (opcode == OPCODE_LWD) ? S_WB : S_IF;
                S_WB:   state <= S_IF;
                S_HALT: state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred; the
    // decode is also gated by reset so requests drop the instant reset rises.
    always_comb begin
        read_m         = 1'b0;
        write_m        = 1'b0;
        i_or_d         = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src         = 1'b0;
        reg_write      = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        alu_src_b      = 1'b0;
        aluop          = 4'd0;
        alu_funct      = 6'd0;
        output_port_we = 1'b0;
        if (!reset) begin
            unique case (state)
                S_IF: begin
                    read_m   = 1'b1;
                    ir_write = input_ready;
                end
                S_EX: begin
                    aluop     = opcode;
                    alu_funct = funct;
                    if (is_add) begin
                        // Result is written back in WB; nothing to strobe here.
                    end else if (is_wwd) begin
                        output_port_we = 1'b1;
                        pc_write       = 1'b1;
                    end else if (opcode == OPCODE_ADI || opcode == OPCODE_LHI ||
                                 opcode == OPCODE_LWD || opcode == OPCODE_SWD) begin
                        alu_src_b = 1'b1;
                    end else if (opcode == OPCODE_JMP) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end else begin
                        pc_write = 1'b1;
                    end
                end
                S_MEM: begin
                    i_or_d   = 1'b1;
                    read_m   = (opcode == OPCODE_LWD);
                    write_m  = (opcode == OPCODE_SWD);
                    pc_write = input_ready && (opcode == OPCODE_SWD);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    reg_dst    = (opcode == OPCODE_RTYPE);
                    mem_to_reg = (opcode == OPCODE_LWD);
                end
                default: ;
            endcase
        end
    end

    // Every retiring instruction is marked by exactly one pc_write pulse.
    tsc_inst_counter #(.WORD_W(WORD_W)) u_inst_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_write),
        .count (num_inst)
    );

endmodule

// File: doc/tsc_multicycle_control.md
# tsc_multicycle_control

Multi-cycle control FSM for the 16-bit TSC datapath: sequences fetch, decode, execute, memory and write-back around the shared ALU, register file and the single unified memory port. Drives the ALU opcode/funct selects, register-file and memory enables, PC/IR load strobes, and the `WWD` output-port strobe. Sits at CPU top level beside the datapath. Owns the memory handshake, the instruction counter and the halt flag.

## Interface
- `WORD_W`, 16: datapath and counter width
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `opcode`  in  4  IR[15:12], valid from ID onward
- `funct`  in  6  IR[5:0]
- `input_ready`  in  1  memory completion for the current `read_m`/`write_m`
- `read_m` / `write_m`  out  1  memory read/write request, held until `input_ready`
- `i_or_d`  out  1  0 = address from PC, 1 = address from ALU result
- `ir_write`  out  1  load IR with memory data
- `pc_write`  out  1  load PC from `pc_src` selection
- `pc_src`  out  1  0 = PC+1, 1 = jump target {PC[15:12], IR[11:0]}
- `reg_write`  out  1  register-file write enable
- `reg_dst`  out  1  0 = rt (IR[9:8]), 1 = rd (IR[7:6])
- `mem_to_reg`  out  1  write-back source: 0 = ALU result, 1 = memory data register
- `alu_src_b`  out  1  0 = read_data2, 1 = sign/zero-extended immediate
- `aluop`  out  4  opcode forwarded to ALU during EX
- `alu_funct`  out  6  funct forwarded to ALU during EX
- `output_port_we`  out  1  one-cycle strobe latching `WWD` value
- `is_halted`  out  1  sticky after `HLT`
- `num_inst`  out  WORD_W  count of retired instructions

## Operation
- States: `IF`, `ID`, `EX`, `MEM`, `WB`, `HALT`; encoded in 3 bits.
- IF: `read_m=1`, `i_or_d=0`; on `input_ready`, `ir_write=1` and go to ID. Otherwise stay in IF.
- ID: decode `opcode`/`funct`.
  - `HLT` (RTYPE, funct 29): go to HALT and set `is_halted`.
  - All others: go to EX.
- EX: `aluop`/`alu_funct` driven. Next state and strobes by opcode:
  - RTYPE ADD (funct 0): go to WB.
  - RTYPE WWD (funct 28): `output_port_we=1`, `pc_write=1`, `pc_src=0`; retire; go to IF.
  - ADI (4), LHI (6): `alu_src_b=1`; go to WB.
  - LWD (7), SWD (8): `alu_src_b=1`; go to MEM.
  - JMP (9): `pc_write=1`, `pc_src=1`; retire; go to IF.
  - Any other opcode/funct: NOP; `pc_write=1`, `pc_src=0`; retire; go to IF.
- MEM: `i_or_d=1`; `read_m=1` (LWD) or `write_m=1` (SWD) held until `input_ready`.
  - On ready, LWD goes to WB.
  - On ready, SWD retires (`pc_write=1`, `pc_src=0`) and goes to IF.
- WB: `reg_write=1`, `pc_write=1`, `pc_src=0`; retire; go to IF.
  - ADD: `reg_dst=1`.
  - ADI, LHI, LWD: `reg_dst=0`.
  - LWD: `mem_to_reg=1`.
- Retire: `num_inst` increments by 1 in the same cycle as the retiring `pc_write`; wraps modulo 2^WORD_W. `HLT` does not count.
- HALT: all enables 0. Absorbing state; only `reset` exits it.
- All strobe outputs are Moore/Mealy decodes of the state register and `opcode`/`funct`/`input_ready`. None is registered separately.

## Timing
- Reset values:
  - State = IF.
  - `num_inst=0`, `is_halted=0`.
  - Every enable/strobe = 0; `aluop`/`alu_funct` = 0.
  - `read_m` asserts in the first cycle after `reset` falls.
- Reset mid-operation takes effect immediately, asynchronously. Any outstanding `read_m`/`write_m` drops in that cycle; a pending memory write is abandoned.
- Minimum cycles with zero-wait memory (`input_ready` high in the request cycle):
  - ADD/ADI/LHI: 4.
  - LWD: 5.
  - SWD: 4.
  - JMP/WWD/NOP: 3.
  - HLT reaches HALT after 2.
- Each wait cycle on `input_ready` adds one cycle to IF or MEM. `input_ready` is ignored outside IF and MEM.
- `read_m` and `write_m` are never high together.

## Structure
- Shared package/header `tsc_opcodes`: `OPCODE_*`, `FUNC_*` constants and the `state_t` encoding. The same constants feed the ALU.
- One sub-module, `tsc_inst_counter`: the WORD_W counter with a synchronous `inc` input and asynchronous `reset`.
- The FSM, next-state logic and output decode live in the top module.

## Test plan
- Reset then ADD r1,r2,r3 with zero-wait memory -> IF, ID, EX, WB over 4 cycles.
  - `reg_write=1` with `reg_dst=1` in cycle 4.
  - `num_inst` goes 0->1.
- LWD with `input_ready` delayed 3 cycles in IF and 2 in MEM -> 10 cycles total.
  - `read_m` held high throughout both waits.
  - `mem_to_reg=1` in WB.
- JMP 0x0ABC -> `pc_write=1`, `pc_src=1` in EX (cycle 3); `num_inst` +1.
- WWD then HLT -> `output_port_we` pulses once in cycle 3.
  - `is_halted=1` after ID of HLT; `num_inst` = 1.
  - No `read_m` for 20 further cycles.
- Assert `reset` in MEM of SWD with `write_m=1` -> `write_m` drops in that cycle.
  - `num_inst` returns to 0.
  - Fetch restarts in IF.
- Preload `num_inst` to 0xFFFF via 65535 NOPs, then one ADI -> `num_inst` wraps to 0x0000.
